// File: rtl/systolic_array_nxn.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_nxn
// Brief    : N x N weight-stationary systolic matrix-vector engine with input
//            skew, output deskew, valid/ready handshakes and double-buffered
//            weights. Define SA_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*DATA_W-1:0] w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*DATA_W-1:0] a_data,
  output logic                out_valid,
  output logic [N*ACC_W-1:0]  out_data,
  output logic                busy
);

  localparam int CNT_W = $clog2(N);
  localparam int IF_W  = $clog2(2*N+1);
  localparam int VP_W  = 2*N-1;

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(N-1);
  localparam logic [CNT_W-1:0] BEAT_ONE  = CNT_W'(1);
  localparam logic [IF_W-1:0]  IF_ONE    = IF_W'(1);

  localparam logic [1:0] ST_NO_W    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_LOADED  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  beat_cnt;
  logic [IF_W-1:0]   inflight;
  logic              w_fire;
  logic              a_fire;
  logic              last_beat;
  logic              commit;

  logic [DATA_W-1:0] shadow   [N][N];
  logic [DATA_W-1:0] weight   [N][N];
  logic [DATA_W-1:0] a_lane   [N];
  logic [DATA_W-1:0] skew_out [N];
  logic [DATA_W-1:0] act_in   [N][N];
  logic [DATA_W-1:0] act_q    [N][N-1];
  logic [ACC_W-1:0]  psum_in  [N][N];
  logic [ACC_W-1:0]  psum_q   [N][N];
  logic [ACC_W-1:0]  prod     [N][N];
  logic [ACC_W-1:0]  deskew_out [N];
  logic [VP_W-1:0]   vpipe;

  // Operands are widened to ACC_W first, so the truncated product is exact and wraps mod 2^ACC_W.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [ACC_W-1:0] ea;
    logic [ACC_W-1:0] eb;
`ifdef SA_SIGNED_EN
    ea = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
    eb = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
`else
    ea = {{(ACC_W-DATA_W){1'b0}}, a};
    eb = {{(ACC_W-DATA_W){1'b0}}, b};
`endif
    return ea * eb;
  endfunction

  // ---------------------------------------------------------------- weight FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_NO_W;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_NO_W:    if (last_beat)        state_nxt = ST_PENDING;
      ST_PENDING: if (inflight == '0)   state_nxt = ST_LOADED;
      ST_LOADED:  if (last_beat)        state_nxt = ST_PENDING;
      default:                          state_nxt = ST_NO_W;
    endcase
  end

  always_comb begin
    w_ready = (state != ST_PENDING);
    a_ready = (state == ST_LOADED);
    commit  = (state == ST_PENDING) && (inflight == '0);
  end

  assign w_fire    = w_valid && w_ready;
  assign a_fire    = a_valid && a_ready;
  assign last_beat = w_fire && (beat_cnt == BEAT_LAST);
  assign busy      = (inflight != '0);

  // Beats shift in at row 0, so the first beat of a load ends up in row N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          shadow[r][c] <= '0;
          weight[r][c] <= '0;
        end
      end
    end else begin
      if (w_fire) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_ONE;
        for (int c = 0; c < N; c++) begin
          shadow[0][c] <= w_data[c*DATA_W +: DATA_W];
        end
        for (int r = 1; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            shadow[r][c] <= shadow[r-1][c];
          end
        end
      end
      if (commit) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            weight[r][c] <= shadow[r][c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else if (a_fire && !out_valid) begin
      inflight <= inflight + IF_ONE;
    end else if (!a_fire && out_valid) begin
      inflight <= inflight - IF_ONE;
    end
  end

  // ---------------------------------------------------------------- input skew
  always_comb begin
    for (int r = 0; r < N; r++) begin
      a_lane[r] = a_fire ? a_data[r*DATA_W +: DATA_W] : '0;
    end
  end

  generate
    for (genvar r = 0; r < N; r++) begin : g_skew
      if (r == 0) begin : g_direct
        assign skew_out[r] = a_lane[r];
      end else begin : g_delay
        logic [DATA_W-1:0] sr [r];
        always_ff @(posedge clk) begin
          if (reset) begin
            for (int i = 0; i < r; i++) begin
              sr[i] <= '0;
            end
          end else begin
            sr[0] <= a_lane[r];
            for (int i = 1; i < r; i++) begin
              sr[i] <= sr[i-1];
            end
          end
        end
        assign skew_out[r] = sr[r-1];
      end
    end
  endgenerate

  // ---------------------------------------------------------------- PE array
  always_comb begin
    for (int r = 0; r < N; r++) begin
      act_in[r][0] = skew_out[r];
      for (int c = 1; c < N; c++) begin
        act_in[r][c] = act_q[r][c-1];
      end
    end
    for (int c = 0; c < N; c++) begin
      psum_in[0][c] = '0;
      for (int r = 1; r < N; r++) begin
        psum_in[r][c] = psum_q[r-1][c];
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        prod[r][c] = mul_ext(act_in[r][c], weight[r][c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          psum_q[r][c] <= '0;
        end
        for (int c = 0; c < N-1; c++) begin
          act_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          psum_q[r][c] <= psum_in[r][c] + prod[r][c];
        end
        for (int c = 0; c < N-1; c++) begin
          act_q[r][c] <= act_in[r][c];
        end
      end
    end
  end

  // ---------------------------------------------------------------- output deskew
  generate
    for (genvar c = 0; c < N; c++) begin : g_deskew
      if (c == N-1) begin : g_direct
        assign deskew_out[c] = psum_q[N-1][c];
      end else begin : g_delay
        logic [ACC_W-1:0] dr [N-1-c];
        always_ff @(posedge clk) begin
          if (reset) begin
            for (int i = 0; i < N-1-c; i++) begin
              dr[i] <= '0;
            end
          end else begin
            dr[0] <= psum_q[N-1][c];
            for (int i = 1; i < N-1-c; i++) begin
              dr[i] <= dr[i-1];
            end
          end
        end
        assign deskew_out[c] = dr[N-2-c];
      end
    end
  endgenerate

  // The valid bit lags the accept by 2N-1 stages; the last one loads the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      vpipe     <= {vpipe[VP_W-2:0], a_fire};
      out_valid <= vpipe[VP_W-1];
      if (vpipe[VP_W-1]) begin
        for (int c = 0; c < N; c++) begin
          out_data[c*ACC_W +: ACC_W] <= deskew_out[c];
        end
      end
    end
  end

endmodule
`default_nettype wire
